// File: rtl/posit_decode_scheduler.sv
// -----------------------------------------------------------------------------
// posit_decode_scheduler
//
// Time-shares a single posit_decoder between the two operands of a posit
// arithmetic request. An operand pair is accepted on in_valid/in_ready, each
// operand is pushed through the decoder's start/done/recieved handshake in
// turn, and both captured field sets are presented together on
// out_valid/out_ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand pair handshake
//   in_single                decode operand A only (B fields forced to 0)
//   posit_a, posit_b         operand posits (32 bit)
//   dec_posit_num            registered operand presented to the decoder
//   dec_start, dec_recieved  decoder control (never both high)
//   dec_done, dec_sign, dec_zero, dec_nar, dec_k, dec_exp, dec_mant
//                            decoder results
//   out_valid/out_ready      decoded pair handshake
//   a_fields, b_fields       {sign, zero, nar, k[5:0], exp[2:0], mant[31:0]}
//   err                      watchdog abort flag
//
// Configuration:
//   POSIT_SCHED_TIMEOUT_EN   when defined, each WAIT state is bounded by
//                            TIMEOUT cycles; on expiry the pending operand's
//                            fields read 0 and err is raised until the output
//                            handshake. When undefined, err is constant 0.
// -----------------------------------------------------------------------------
module posit_decode_scheduler #(
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_single,
    input  logic [31:0]       posit_a,
    input  logic [31:0]       posit_b,
    output logic [31:0]       dec_posit_num,
    output logic              dec_start,
    output logic              dec_recieved,
    input  logic              dec_done,
    input  logic              dec_sign,
    input  logic              dec_zero,
    input  logic              dec_nar,
    input  logic signed [5:0] dec_k,
    input  logic [2:0]        dec_exp,
    input  logic [31:0]       dec_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [43:0]       a_fields,
    output logic [43:0]       b_fields,
    output logic              err
);

    typedef enum logic [3:0] {
        IDLE,
        FLUSH,
        START_A,
        WAIT_A,
        ACK_A,
        START_B,
        WAIT_B,
        ACK_B,
        OUT
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [31:0] b_q;
    logic        single_q;

    logic        accept;
    logic        cap_a;
    logic        cap_b;
    logic        load_b;
    logic        wd_expired;
    logic [43:0] dec_fields;

    // Bit-exact packing of the decoder result; k keeps its two's-complement form.
    assign dec_fields = {dec_sign, dec_zero, dec_nar, dec_k, dec_exp, dec_mant};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        nxt    = state;
        accept = 1'b0;
        cap_a  = 1'b0;
        cap_b  = 1'b0;
        load_b = 1'b0;
        case (state)
            IDLE: begin
                // A decoder still showing done (e.g. we were reset mid-decode)
                // must be acknowledged before any new request is started.
                if (dec_done) begin
                    nxt = FLUSH;
                end else if (in_valid && in_ready) begin
                    accept = 1'b1;
                    nxt    = START_A;
                end
            end
            FLUSH: begin
                if (!dec_done) nxt = IDLE;
            end
            START_A: nxt = WAIT_A;
            WAIT_A: begin
                if (dec_done) begin
                    cap_a = 1'b1;
                    nxt   = ACK_A;
                end else if (wd_expired) begin
                    nxt = OUT;
                end
            end
            ACK_A: begin
                if (!dec_done) begin
                    if (single_q) begin
                        nxt = OUT;
                    end else begin
                        load_b = 1'b1;
                        nxt    = START_B;
                    end
                end
            end
            START_B: nxt = WAIT_B;
            WAIT_B: begin
                if (dec_done) begin
                    cap_b = 1'b1;
                    nxt   = ACK_B;
                end else if (wd_expired) begin
                    nxt = OUT;
                end
            end
            ACK_B: begin
                if (!dec_done) nxt = OUT;
            end
            OUT: begin
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs. Outputs are decoded from the next state so
    // they line up with the state they describe without a combinational path.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            dec_start     <= 1'b0;
            dec_recieved  <= 1'b0;
            dec_posit_num <= '0;
            out_valid     <= 1'b0;
            a_fields      <= '0;
            b_fields      <= '0;
            b_q           <= '0;
            single_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state        <= nxt;
            in_ready     <= (nxt == IDLE) && !dec_done;
            dec_start    <= (nxt == START_A) || (nxt == START_B);
            dec_recieved <= (nxt == FLUSH) || (nxt == ACK_A) || (nxt == ACK_B);
            out_valid    <= (nxt == OUT);

            if (accept) begin
                dec_posit_num <= posit_a;
                b_q           <= posit_b;
                single_q      <= in_single;
                // Clearing here makes un-decoded fields (single mode, watchdog
                // abort) read as zero without extra per-path logic.
                a_fields      <= '0;
                b_fields      <= '0;
            end
            if (load_b) dec_posit_num <= b_q;
            if (cap_a)  a_fields      <= dec_fields;
            if (cap_b)  b_fields      <= dec_fields;
        end
    end

    // -------------------------------------------------------------------------
    // Optional watchdog on the WAIT states
    // -------------------------------------------------------------------------
`ifdef POSIT_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Counter is 0 on the first WAIT cycle, so expiry after TIMEOUT cycles.
    assign wd_expired = ((state == WAIT_A) || (state == WAIT_B)) && !dec_done &&
                        (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((nxt == WAIT_A) || (nxt == WAIT_B)) begin
                if (state != nxt) wd_cnt <= '0;
                else              wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expired)                    err_q <= 1'b1;
            else if (state == OUT && out_ready) err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_posit_decode_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for posit_decode_scheduler. A behavioural posit<32,3> decoder model
// answers the scheduler's handshake with random latency; a scoreboard holds the
// expected field pair per accepted request and a single monitor compares the
// DUT against it every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_posit_decode_scheduler;

`ifdef POSIT_SCHED_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 63;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_single;
    logic [31:0]       posit_a;
    logic [31:0]       posit_b;
    logic [31:0]       dec_posit_num;
    logic              dec_start;
    logic              dec_recieved;
    logic              dec_done;
    logic              dec_sign;
    logic              dec_zero;
    logic              dec_nar;
    logic signed [5:0] dec_k;
    logic [2:0]        dec_exp;
    logic [31:0]       dec_mant;
    logic              out_valid;
    logic              out_ready;
    logic [43:0]       a_fields;
    logic [43:0]       b_fields;
    logic              err;

    always #5 clk = ~clk;

    posit_decode_scheduler #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_single(in_single),
        .posit_a(posit_a), .posit_b(posit_b),
        .dec_posit_num(dec_posit_num), .dec_start(dec_start), .dec_recieved(dec_recieved),
        .dec_done(dec_done), .dec_sign(dec_sign), .dec_zero(dec_zero), .dec_nar(dec_nar),
        .dec_k(dec_k), .dec_exp(dec_exp), .dec_mant(dec_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_fields(a_fields), .b_fields(b_fields), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference posit<32,es=3> decode: {sign, zero, nar, k, exp, mant}.
    function automatic logic [43:0] ref_decode(input logic [31:0] p);
        logic [31:0]       x;
        logic [31:0]       sh;
        logic signed [5:0] k;
        logic              r0;
        int                run;
        if (p == 32'h0)        return {1'b0, 1'b1, 1'b0, 41'd0};
        if (p == 32'h80000000) return {1'b1, 1'b0, 1'b1, 41'd0};
        x   = p[31] ? (~p + 32'd1) : p;
        r0  = x[30];
        run = 0;
        while (run < 31 && x[30 - run] == r0) run++;
        k   = r0 ? 6'(run - 1) : 6'(-run);
        sh  = x << (run + 2);
        return {p[31], 1'b0, 1'b0, k, sh[31:29], 1'b1, sh[28:0], 2'b00};
    endfunction

    // ---------------- decoder model ----------------
    bit          dec_enable   = 1'b1;
    int          lat_override = -1;
    bit          busy         = 1'b0;
    int          busy_cnt     = 0;
    logic [31:0] held;

    always @(negedge clk) begin
        if (dec_done && dec_recieved) begin
            dec_done = 1'b0;
            {dec_sign, dec_zero, dec_nar, dec_k, dec_exp} = 12'($urandom);
            dec_mant = $urandom;
        end
        if (busy) begin
            if (busy_cnt == 0) begin
                busy = 1'b0;
                if (dec_enable) begin
                    {dec_sign, dec_zero, dec_nar, dec_k, dec_exp, dec_mant} = ref_decode(held);
                    dec_done = 1'b1;
                end
            end else begin
                busy_cnt--;
            end
        end
        if (dec_start) begin
            busy     = 1'b1;
            busy_cnt = (lat_override >= 0) ? lat_override : int'($urandom_range(0, 4));
            held     = dec_posit_num;
        end
    end

    // ---------------- consumer ----------------
    int cons_mode = 2; // 0 random, 1 hold low, 2 always ready
    always @(negedge clk) begin
        case (cons_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [43:0] ea;
        logic [43:0] eb;
        bit          eerr;
        int          starts;
    } txn_t;

    txn_t        exp_q[$];
    int          starts_seen = 0;
    bit          expect_timeout = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    logic [43:0] prev_a;
    logic [43:0] prev_b;

    always @(negedge clk) begin
        txn_t t;
        #2;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            check("start_recv_exclusive", {63'd0, dec_start & dec_recieved}, 64'd0);
            if (dec_start) begin
                starts_seen++;
                check("start_has_txn", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0)
                    check("dec_posit_num", {32'd0, dec_posit_num},
                          {32'd0, (starts_seen == 1) ? exp_q[0].a : exp_q[0].b});
            end
            if (prev_valid && !prev_ready) begin
                check("out_valid_held", {63'd0, out_valid}, 64'd1);
                check("a_fields_stable", {20'd0, a_fields}, {20'd0, prev_a});
                check("b_fields_stable", {20'd0, b_fields}, {20'd0, prev_b});
            end
            if (out_valid) check("in_ready_low_in_out", {63'd0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
                check("out_has_txn", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    check("a_fields", {20'd0, a_fields}, {20'd0, t.ea});
                    check("b_fields", {20'd0, b_fields}, {20'd0, t.eb});
                    check("err", {63'd0, err}, {63'd0, t.eerr});
                    check("start_count", 64'(starts_seen), 64'(t.starts));
                end
                starts_seen = 0;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_a     = a_fields;
            prev_b     = b_fields;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit single);
        txn_t t;
        int   n = 0;
        @(negedge clk); #1;
        in_valid  = 1'b1;
        posit_a   = a;
        posit_b   = b;
        in_single = single;
        while (!(in_ready && !dec_done)) begin
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk); #1;
        end
        @(posedge clk);
        t.a      = a;
        t.b      = b;
        t.eerr   = expect_timeout;
        t.ea     = expect_timeout ? 44'd0 : ref_decode(a);
        t.eb     = (single || expect_timeout) ? 44'd0 : ref_decode(b);
        t.starts = (single || expect_timeout) ? 1 : 2;
        exp_q.push_back(t);
        #1;
        in_valid = 1'b0;
        posit_a  = $urandom;
        posit_b  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                check("drain_timeout", 64'd0, 64'd1);
                exp_q.delete();
                return;
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid) begin
            @(negedge clk); #1;
            n++;
            if (n > 200) begin
                check(name, 64'd0, 64'd1);
                return;
            end
        end
    endtask

    function automatic logic [31:0] rand_posit();
        int sel = int'($urandom_range(0, 7));
        if (sel == 0) return 32'h0;
        if (sel == 1) return 32'h80000000;
        if (sel == 2) return 32'h7FFFFFFF;
        return $urandom;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int pulses;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_single = 1'b0;
        posit_a   = '0;
        posit_b   = '0;
        dec_done  = 1'b0;
        dec_sign  = 1'b0;
        dec_zero  = 1'b0;
        dec_nar   = 1'b0;
        dec_k     = '0;
        dec_exp   = '0;
        dec_mant  = '0;
        out_ready = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_dec_start", {63'd0, dec_start}, 64'd0);
        check("rst_dec_recieved", {63'd0, dec_recieved}, 64'd0);
        check("rst_dec_posit_num", {32'd0, dec_posit_num}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_a_fields", {20'd0, a_fields}, 64'd0);
        check("rst_b_fields", {20'd0, b_fields}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Pin the reference model with hand-derived encodings.
        check("model_one", {20'd0, ref_decode(32'h40000000)}, {20'd0, 44'h000_8000_0000});
        check("model_neg_one", {20'd0, ref_decode(32'hC0000000)}, {20'd0, 44'h800_8000_0000});
        check("model_zero", {20'd0, ref_decode(32'h00000000)}, {20'd0, 44'h400_0000_0000});
        check("model_nar", {20'd0, ref_decode(32'h80000000)}, {20'd0, 44'hA00_0000_0000});
        check("model_maxpos", {20'd0, ref_decode(32'h7FFFFFFF)}, {20'd0, 44'h0F0_8000_0000});

        // Pair 1.0 / -1.0 with the consumer stalling for 10 cycles.
        cons_mode = 1;
        send(32'h40000000, 32'hC0000000, 1'b0);
        wait_valid("valid_timeout_pair");
        check("pair_a_literal", {20'd0, a_fields}, {20'd0, 44'h000_8000_0000});
        check("pair_b_literal", {20'd0, b_fields}, {20'd0, 44'h800_8000_0000});
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (dec_start) pulses++;
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        check("stall_no_start", 64'(pulses), 64'd0);
        cons_mode = 2;
        drain();

        // Single mode, zero operand.
        cons_mode = 1;
        send(32'h00000000, $urandom, 1'b1);
        wait_valid("valid_timeout_single");
        check("single_a_literal", {20'd0, a_fields}, {20'd0, 44'h400_0000_0000});
        check("single_b_zero", {20'd0, b_fields}, 64'd0);
        cons_mode = 2;
        drain();

        // NaR and maximum positive posit.
        cons_mode = 1;
        send(32'h80000000, 32'h7FFFFFFF, 1'b0);
        wait_valid("valid_timeout_nar");
        check("nar_flag", {63'd0, a_fields[41]}, 64'd1);
        check("maxpos_k", {58'd0, b_fields[40:35]}, 64'd30);
        cons_mode = 2;
        drain();

        // Randomized traffic.
        cons_mode = 0;
        for (int i = 0; i < 40; i++) begin
            send(rand_posit(), rand_posit(), ($urandom_range(0, 3) == 0));
            drain();
        end

        // Reset while decoding operand B; decoder completes afterwards.
        cons_mode    = 2;
        lat_override = 8;
        send($urandom, $urandom, 1'b0);
        n = 0;
        while (starts_seen < 2 && n < 100) begin @(negedge clk); n++; end
        check("reached_start_b", 64'(starts_seen), 64'd2);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        starts_seen = 0;
        #1;
        check("async_clear_a", {20'd0, a_fields}, 64'd0);
        check("async_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk); #1;
        rst          = 1'b0;
        lat_override = -1;
        n = 0;
        while (!dec_done && n < 50) begin @(negedge clk); #1; n++; end
        check("decoder_done_after_reset", {63'd0, dec_done}, 64'd1);
        @(negedge clk); #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        check("flush_recieved", {63'd0, dec_recieved}, 64'd1);
        @(negedge clk); #1;
        check("ready_after_flush", {63'd0, in_ready}, 64'd1);
        check("no_output_after_flush", {63'd0, out_valid}, 64'd0);
        send(32'h40000000, 32'h7FFFFFFF, 1'b0);
        drain();

`ifdef POSIT_SCHED_TIMEOUT_EN
        // Watchdog: decoder never answers.
        dec_enable     = 1'b0;
        expect_timeout = 1'b1;
        cons_mode      = 1;
        send($urandom, $urandom, 1'b0);
        n = 0;
        while (!dec_start && n < 20) begin @(negedge clk); #1; n++; end
        check("timeout_start_seen", {63'd0, dec_start}, 64'd1);
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); #1; n++; end
        check("timeout_latency", 64'(n), 64'd9);
        check("timeout_err", {63'd0, err}, 64'd1);
        check("timeout_a_zero", {20'd0, a_fields}, 64'd0);
        cons_mode = 2;
        drain();
        expect_timeout = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("err_cleared", {63'd0, err}, 64'd0);
        dec_enable = 1'b1;
`endif

        repeat (3) @(negedge clk);
        check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/posit_decode_scheduler.md
# posit_decode_scheduler

Sequencer that time-shares one `posit_decoder` instance between the two operands of a posit arithmetic request. It accepts an operand pair on a valid/ready handshake and drives the decoder's start/done/received handshake once per operand. It captures each decoded field set and presents both sets together on a valid/ready output to the downstream arithmetic stage.

## Interface
- `TIMEOUT`, 63: watchdog limit, in cycles waiting for `dec_done`. Used only with the macro in Configuration.
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset. Asynchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: scheduler can accept a pair.
- `in_single` in 1: decode operand A only; B fields are forced to 0.
- `posit_a`, `posit_b` in 32 each: operand posits.
- `dec_posit_num` out 32: to decoder `posit_num`. Registered.
- `dec_start` out 1: to decoder `start`.
- `dec_recieved` out 1: to decoder `recieved`.
- `dec_done`, `dec_sign`, `dec_zero`, `dec_nar` in 1 each: from decoder.
- `dec_k` in 6 (signed), `dec_exp` in 3, `dec_mant` in 32: from decoder.
- `out_valid` out 1: decoded pair valid.
- `out_ready` in 1: consumer accepts the pair.
- `a_fields`, `b_fields` out 44 each: packed as {sign, zero, nar, k[5:0], exp[2:0], mant[31:0]}, MSB first.
- `err` out 1: watchdog abort flag. Tied to 0 without the macro.

## Operation
- States: IDLE, FLUSH, START_A, WAIT_A, ACK_A, START_B, WAIT_B, ACK_B, OUT.
- IDLE:
  - `in_ready`=1 only while `dec_done`=0.
  - If `dec_done`=1, go to FLUSH. This covers a decoder left in its complete state by a scheduler reset mid-operation.
  - On `in_valid && in_ready`: register `posit_a`, `posit_b` and `in_single`; load `dec_posit_num`=A; go to START_A.
- FLUSH: `dec_recieved`=1 until `dec_done`=0, then go to IDLE. Nothing is captured.
- START_A / START_B: `dec_start`=1 for exactly one cycle, then go to the matching WAIT state.
- WAIT_x: hold until `dec_done`=1.
  - On that cycle, capture all `dec_*` fields into the x field register.
  - Go to ACK_x.
- ACK_x: `dec_recieved`=1 while `dec_done`=1. When `dec_done`=0, leave ACK_x:
  - From ACK_A: if single mode, B fields are 0 and go to OUT; otherwise set `dec_posit_num`=B and go to START_B.
  - From ACK_B: go to OUT.
- OUT:
  - `out_valid`=1; `a_fields` and `b_fields` are stable.
  - On `out_ready`=1, go to IDLE.
  - `out_ready` may be high before `out_valid`. No combinational path from `out_ready` to `in_ready`.
- `dec_start` and `dec_recieved` are never 1 in the same cycle.
- `dec_posit_num` is stable from START_x through ACK_x.
- Field capture is bit-exact, no arithmetic. `k` keeps its two's-complement encoding, so k=-31 is 6'b100001.
- ZERO/NAR results are captured like any other; the scheduler does not short-circuit them.

## Timing
- All outputs registered.
- Reset values: `in_ready`=0 in the reset cycle, then follows IDLE rules. `dec_start`=0, `dec_recieved`=0, `dec_posit_num`=0, `out_valid`=0, `a_fields`=0, `b_fields`=0, `err`=0. State = IDLE.
- Per-operand latency = decoder latency + 1 (START) + 1 (capture) + 1 (ACK, decoder drops `done` next edge).
- Pair latency, accept to `out_valid`: sum of both operand latencies + 1.
- Reset asserted mid-operation: state returns to IDLE and field registers clear asynchronously. The decoder is not reset by this block; FLUSH recovers it.
- Back-to-back requests: next `in_ready` is the cycle after the OUT handshake, provided `dec_done`=0.

## Configuration
- `POSIT_SCHED_TIMEOUT_EN`
- Defined:
  - A cycle counter clears on entry to each WAIT_x and increments every WAIT_x cycle.
  - When it reaches `TIMEOUT` without `dec_done`: set `err`=1, fields of the pending operand = 0, go to OUT.
  - `err` stays 1 until the OUT handshake completes, then clears.
- Undefined: no counter; `err` is constant 0; WAIT_x waits indefinitely.

## Test plan
- A=0x40000000, B=0xC0000000, pair mode:
  - A: sign=0, k=0, exp=0, mant=0x80000000.
  - B: sign=1, same k/exp/mant as A.
  - Exactly two `dec_start` pulses; `out_valid` held until `out_ready`.
- Single mode, A=0x00000000: one `dec_start`; `a_fields` zero=1, nar=0; `b_fields`=0.
- A=0x80000000 (NaR), B=0x7FFFFFFF: `a_fields` nar=1. `b_fields` k field = 6'd30 (decoder's k for the maximum positive posit); no deadlock.
- Reset pulsed while in WAIT_B with decoder later raising `done`:
  - Scheduler goes to IDLE, then FLUSH; `in_ready` stays 0 until `dec_done` falls.
  - The next pair then decodes correctly.
- `out_ready` held low for 10 cycles: `out_valid` and fields stay stable, `in_ready`=0, no `dec_start` pulses.
- With `POSIT_SCHED_TIMEOUT_EN`, TIMEOUT=8, `dec_done` tied 0: `err`=1 and `out_valid`=1 exactly 9 cycles after START_A; `err` clears after the OUT handshake.
